// File: rtl/multdiv_pkg.sv
// Shared definitions for the multdiv unit: default widths, divider state encoding,
// and the conditional two's-complement negate used by both multiplier and divider.
package multdiv_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 6;
  localparam int MAX_W     = 64;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    DONE     = 2'd2,
    DONE_EXC = 2'd3
  } div_state_e;

  // Callers zero-extend into MAX_W and truncate back; the low bits are the
  // correct modular negation at any narrower width.
  function automatic logic [MAX_W-1:0] cond_negate(input logic [MAX_W-1:0] v,
                                                   input logic             neg);
    return neg ? (~v + MAX_W'(1)) : v;
  endfunction

endpackage

// File: rtl/divider_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] shifted;
  logic           fits;

  // Remainder stays below the divisor, so the extra top bit of shifted only
  // matters for divisors at or near 2^(WIDTH-1).
  always_comb begin
    shifted  = {rem, q[WIDTH-1]};
    fits     = (shifted >= {1'b0, divisor});
    rem_next = fits ? WIDTH'(shifted - {1'b0, divisor}) : WIDTH'(shifted);
    q_next   = {q[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/divider.sv
// Multi-cycle signed restoring divider with start strobe, one-cycle ready pulse
// and divide-by-zero flag; a start in any state (re)launches an operation.
//
// state    | meaning
// IDLE     | waiting for ctrl_DIV
// RUN      | one restoring step per cycle, cnt counts 0..WIDTH-1
// DONE     | quotient registered, data_resultRDY high this cycle
// DONE_EXC | divisor was zero; result/flag/RDY registered on the next edge
module divider
  import multdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_resultRDY,
  output logic             data_exception,
  output logic             busy
);

  div_state_e       state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, divisor;
  logic [WIDTH-1:0] rem_next, quo_next;
  logic [WIDTH-1:0] abs_a, abs_b, quo_signed;
  logic             sign_q;
  logic             divb_zero, last_step;
  logic             step_en, finish, exc_done;

  assign abs_a      = WIDTH'(cond_negate(MAX_W'(data_operandA), data_operandA[WIDTH-1]));
  assign abs_b      = WIDTH'(cond_negate(MAX_W'(data_operandB), data_operandB[WIDTH-1]));
  assign quo_signed = WIDTH'(cond_negate(MAX_W'(quo_next), sign_q));
  assign divb_zero  = (data_operandB == '0);
  assign last_step  = (cnt == CNT_W'(WIDTH - 1));

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .q        (quo),
    .divisor  (divisor),
    .rem_next (rem_next),
    .q_next   (quo_next)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (ctrl_DIV) begin
      state_next = divb_zero ? DONE_EXC : RUN;
    end else begin
      case (state)
        RUN:     state_next = last_step ? DONE : RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = (state == RUN);
    step_en  = (state == RUN) && !ctrl_DIV;
    finish   = step_en && last_step;
    exc_done = (state == DONE_EXC);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt            <= '0;
      rem            <= '0;
      quo            <= '0;
      divisor        <= '0;
      sign_q         <= 1'b0;
      data_result    <= '0;
      data_resultRDY <= 1'b0;
      data_exception <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_DIV) begin
        rem            <= '0;
        quo            <= abs_a;
        divisor        <= abs_b;
        sign_q         <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        cnt            <= '0;
        data_exception <= 1'b0;
      end else if (step_en) begin
        rem <= rem_next;
        quo <= quo_next;
        cnt <= cnt + CNT_W'(1);
        if (finish) begin
          data_result    <= quo_signed;
          data_resultRDY <= 1'b1;
          data_exception <= 1'b0;
        end
      end
      // A pending divide-by-zero completion still reports even if a new start
      // arrives on the same edge; the new op clears the flag when it finishes.
      if (exc_done) begin
        data_result    <= '0;
        data_exception <= 1'b1;
        data_resultRDY <= 1'b1;
      end
    end
  end

endmodule
